// File: rtl/fetch_pkg.sv
// fetch_pkg: shared PC-mux select and fetch FSM state encodings
package fetch_pkg;
  typedef enum logic [1:0] {SEQ = 2'd0, PRED = 2'd1, REDIR_LIVE = 2'd2, REDIR_SAVED = 2'd3} pc_sel_t;
  typedef enum logic [1:0] {FETCH = 2'd0, STALL = 2'd1, DRAIN = 2'd2} fetch_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences PC enable/mux select and the icache read handshake
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   redirect, redirect_pc       EX redirect pulse and its target
//   predict_taken               BTB hit+taken for the current PC
//   icache_resp, icache_rdata   icache read completion and instruction word
//   id_ready                    decode accepts if_instr
//   icache_read                 read request at current PC
//   pc_load, pc_sel             PC enable and next-PC source
//   saved_pc                    redirect target latched during an outstanding read
//   if_valid, if_instr          instruction to decode
//   redirect_cnt                saturating count of redirects
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             predict_taken,
  input  logic             icache_resp,
  input  logic [31:0]      icache_rdata,
  input  logic             id_ready,
  output logic             icache_read,
  output logic             pc_load,
  output logic [1:0]       pc_sel,
  output logic [WIDTH-1:0] saved_pc,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [CNT_W-1:0] redirect_cnt
);
  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] saved_q, saved_d;
  logic [31:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q;
  logic             rd, ld, vld;
  pc_sel_t          sel;
  logic [31:0]      instr;
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    hold_d  = hold_q;
    rd      = 1'b0;
    ld      = 1'b0;
    sel     = SEQ;
    vld     = 1'b0;
    instr   = '0;
    case (state_q)
      FETCH: begin
        rd = 1'b1;
        if (icache_resp) begin
          ld = 1'b1;
          if (redirect) begin
            sel = REDIR_LIVE;
          end else begin
            sel   = predict_taken ? PRED : SEQ;
            vld   = 1'b1;
            instr = icache_rdata;
            if (!id_ready) begin
              hold_d  = icache_rdata;
              state_d = STALL;
            end
          end
        end else if (redirect) begin
          // PC must hold while the read is in flight; park the target
          saved_d = redirect_pc;
          state_d = DRAIN;
        end
      end
      STALL: begin
        instr = hold_q;
        if (redirect) begin
          ld      = 1'b1;
          sel     = REDIR_LIVE;
          state_d = FETCH;
        end else begin
          vld     = 1'b1;
          state_d = id_ready ? FETCH : STALL;
        end
      end
      DRAIN: begin
        rd = 1'b1;
        if (icache_resp) begin
          ld      = 1'b1;
          sel     = redirect ? REDIR_LIVE : REDIR_SAVED;
          state_d = FETCH;
        end else if (redirect) begin
          saved_d = redirect_pc;
        end
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      saved_q <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      hold_q  <= hold_d;
      if (redirect && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign icache_read  = rst_n & rd;
  assign pc_load      = rst_n & ld;
  assign pc_sel       = rst_n ? sel : SEQ;
  assign if_valid     = rst_n & vld;
  assign if_instr     = rst_n ? instr : '0;
  assign saved_pc     = rst_n ? saved_q : '0;
  assign redirect_cnt = rst_n ? cnt_q : '0;
endmodule
